scan_mux: RTL and testbench

//  Parametrised N:1 registered multiplexer, successor of the 2:1 mux family. Selects one of

---
 rtl/scan_mux_pkg.sv | 12 +
 rtl/scan_mux_dwell_ctr.sv | 31 +++
 rtl/scan_mux.sv | 118 +++++++++++
 tb/tb_scan_mux.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux block: FSM state encoding and mode input codes.
package scan_mux_pkg;

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : scan_mux_pkg

// File: rtl/scan_mux_dwell_ctr.sv
// Dwell counter for scan_mux: counts 0..DWELL-1 while enabled, wraps at terminal count.
// o_tc is asserted only while enabled, so a held counter never signals terminal count.
module scan_mux_dwell_ctr #(
  parameter int DWELL = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int              CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == LAST);

  // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : scan_mux_dwell_ctr

// File: rtl/scan_mux.sv
// N:1 registered multiplexer with manual channel load and automatic round-robin scan.
// Optional break-before-make blanking on channel change: define SCAN_MUX_BLANK_EN.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 16,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_load,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      switched,
  output logic                      sel_err
);

  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  state_e           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_switched;
  logic             r_sel_err;

  state_e           w_state_nxt;
  logic             w_sel_ok;
  logic             w_load_ok;
  logic             w_tc;
  logic             w_ctr_clr;
  logic             w_ctr_en;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             w_switch;
  logic [WIDTH-1:0] w_data;
  logic             w_valid;

  // Behaviour in each cycle follows the mode input directly; r_state records it.
  assign w_state_nxt = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
  assign w_sel_ok    = ({1'b0, sel} < CH_LIM);
  assign w_load_ok   = sel_load && w_sel_ok;

  // Counter idles at 0 in manual; parked on scan exit and restarted on any valid load.
  assign w_ctr_en  = (w_state_nxt == ST_SCAN);
  assign w_ctr_clr = w_load_ok || ((r_state == ST_SCAN) && (w_state_nxt == ST_MANUAL));

  scan_mux_dwell_ctr #(
    .DWELL (DWELL)
  ) u_dwell_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_ctr_clr),
    .i_en  (w_ctr_en),
    .o_tc  (w_tc)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel_nxt = r_sel;
    if (w_load_ok) begin
      w_sel_nxt = sel;
    end else if (w_tc) begin
      w_sel_nxt = (r_sel == LAST_CH) ? '0 : r_sel + 1'b1;
    end
  end

  assign w_switch = (w_sel_nxt != r_sel);

  always_comb begin
    w_data  = '0;
    w_valid = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_sel_nxt == SEL_W'(c)) begin
        w_data  = in_data[c*WIDTH +: WIDTH];
        w_valid = in_valid[c];
      end
    end
`ifdef SCAN_MUX_BLANK_EN
    if (w_switch) begin
      w_data  = '0;
      w_valid = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_MANUAL;
      r_sel      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_switched <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_data     <= w_data;
      r_valid    <= w_valid;
      r_switched <= w_switch;
      r_sel_err  <= sel_load && !w_sel_ok;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign cur_sel   = r_sel;
  assign switched  = r_switched;
  assign sel_err   = r_sel_err;

endmodule : scan_mux

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 4-channel/DWELL=4 instance and a 3-channel/DWELL=2 instance.
// Expectations account for blanking when SCAN_MUX_BLANK_EN is defined.
module tb_scan_mux;

`ifdef SCAN_MUX_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: 4 channels, DWELL=4
  logic [31:0] a_data;
  logic [3:0]  a_valid;
  logic        a_mode;
  logic [1:0]  a_sel;
  logic        a_load;
  logic [7:0]  a_out_data;
  logic        a_out_valid;
  logic [1:0]  a_cur_sel;
  logic        a_switched;
  logic        a_sel_err;

  // Instance B: 3 channels, DWELL=2
  logic [23:0] b_data;
  logic [2:0]  b_valid;
  logic        b_mode;
  logic [1:0]  b_sel;
  logic        b_load;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic [1:0]  b_cur_sel;
  logic        b_switched;
  logic        b_sel_err;

  scan_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (a_data),
    .in_valid  (a_valid),
    .mode      (a_mode),
    .sel       (a_sel),
    .sel_load  (a_load),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .cur_sel   (a_cur_sel),
    .switched  (a_switched),
    .sel_err   (a_sel_err)
  );

  scan_mux #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (b_data),
    .in_valid  (b_valid),
    .mode      (b_mode),
    .sel       (b_sel),
    .sel_load  (b_load),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .cur_sel   (b_cur_sel),
    .switched  (b_switched),
    .sel_err   (b_sel_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output check of instance A against channel ch and switch flag sw.
  task automatic check_a(input string tag, input int ch, input bit sw, input bit err);
    logic [7:0] exp_d;
    logic       exp_v;
    exp_d = (BLANK && sw) ? 8'h00 : 8'(8'hA0 + ch);
    exp_v = (BLANK && sw) ? 1'b0 : a_valid[ch];
    check({tag, ".sel"},   32'(a_cur_sel),   32'(ch));
    check({tag, ".sw"},    32'(a_switched),  32'(sw));
    check({tag, ".err"},   32'(a_sel_err),   32'(err));
    check({tag, ".data"},  32'(a_out_data),  32'(exp_d));
    check({tag, ".valid"}, 32'(a_out_valid), 32'(exp_v));
  endtask

  task automatic check_b(input string tag, input int ch, input bit sw, input bit err);
    logic [7:0] exp_d;
    logic       exp_v;
    exp_d = (BLANK && sw) ? 8'h00 : 8'(8'hB0 + ch);
    exp_v = (BLANK && sw) ? 1'b0 : b_valid[ch];
    check({tag, ".sel"},   32'(b_cur_sel),   32'(ch));
    check({tag, ".sw"},    32'(b_switched),  32'(sw));
    check({tag, ".err"},   32'(b_sel_err),   32'(err));
    check({tag, ".data"},  32'(b_out_data),  32'(exp_d));
    check({tag, ".valid"}, 32'(b_out_valid), 32'(exp_v));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".a_data"},  32'(a_out_data),  32'h0);
    check({tag, ".a_valid"}, 32'(a_out_valid), 32'h0);
    check({tag, ".a_sel"},   32'(a_cur_sel),   32'h0);
    check({tag, ".a_sw"},    32'(a_switched),  32'h0);
    check({tag, ".a_err"},   32'(a_sel_err),   32'h0);
    check({tag, ".b_data"},  32'(b_out_data),  32'h0);
    check({tag, ".b_valid"}, 32'(b_out_valid), 32'h0);
    check({tag, ".b_sel"},   32'(b_cur_sel),   32'h0);
  endtask

  initial begin
    a_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a_valid = 4'b1101;
    b_data  = {8'hB2, 8'hB1, 8'hB0};
    b_valid = 3'b111;
    rst_n   = 1'b0;

    // Reset held 3 cycles while inputs toggle
    for (int i = 0; i < 3; i++) begin
      a_mode = i[0]; a_sel = 2'(i + 1); a_load = 1'b1;
      b_mode = ~i[0]; b_sel = 2'd3;     b_load = 1'b1;
      tick();
      check_zero($sformatf("rst%0d", i));
    end

    // Leave reset in manual mode on channel 0
    a_mode = 1'b0; a_load = 1'b0; a_sel = 2'd0;
    b_mode = 1'b0; b_load = 1'b0; b_sel = 2'd0;
    rst_n  = 1'b1;
    tick();
    check_a("a_idle", 0, 1'b0, 1'b0);

    // Manual load of channel 2, then reload of the same channel
    a_sel = 2'd2; a_load = 1'b1;
    tick();
    check_a("a_ld2", 2, 1'b1, 1'b0);
    a_load = 1'b0;
    tick();
    check_a("a_hold2", 2, 1'b0, 1'b0);
    a_load = 1'b1;
    tick();
    check_a("a_reld2", 2, 1'b0, 1'b0);

    // Channel 1 has in_valid low
    a_sel = 2'd1;
    tick();
    check_a("a_ld1", 1, 1'b1, 1'b0);
    a_load = 1'b0;
    tick();
    check_a("a_hold1", 1, 1'b0, 1'b0);

    // Back to channel 0, then scan
    a_sel = 2'd0; a_load = 1'b1;
    tick();
    check_a("a_ld0", 0, 1'b1, 1'b0);
    a_load = 1'b0;
    a_mode = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      tick();
      check_a($sformatf("a_scan%0d", k), (k / 4) % 4, (k % 4) == 0, 1'b0);
    end

    // Load channel 1 in the cycle the dwell counter sits at terminal count on channel 2
    a_sel = 2'd1; a_load = 1'b1;
    tick();
    check_a("a_tcld", 1, 1'b1, 1'b0);
    a_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_a($sformatf("a_post%0d", k), 1, 1'b0, 1'b0);
    end
    tick();
    check_a("a_adv2", 2, 1'b1, 1'b0);

    // Scan -> manual freezes the channel
    a_mode = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_a($sformatf("a_frz%0d", k), 2, 1'b0, 1'b0);
    end

    // Instance B: out-of-range load in manual mode
    b_sel = 2'd3; b_load = 1'b1;
    tick();
    check_b("b_bad", 0, 1'b0, 1'b1);
    b_load = 1'b0;
    tick();
    check_b("b_badclr", 0, 1'b0, 1'b0);
    b_sel = 2'd2; b_load = 1'b1;
    tick();
    check_b("b_ld2", 2, 1'b1, 1'b0);
    b_load = 1'b0;

    // Scan wraps 2 -> 0 and never visits code 3
    b_mode = 1'b1;
    tick(); check_b("b_s1", 2, 1'b0, 1'b0);
    tick(); check_b("b_s2", 0, 1'b1, 1'b0);
    tick(); check_b("b_s3", 0, 1'b0, 1'b0);
    tick(); check_b("b_s4", 1, 1'b1, 1'b0);
    b_sel = 2'd3; b_load = 1'b1;
    tick(); check_b("b_s5err", 1, 1'b0, 1'b1);
    b_load = 1'b0;
    tick(); check_b("b_s6", 2, 1'b1, 1'b0);
    tick(); check_b("b_s7", 2, 1'b0, 1'b0);
    tick(); check_b("b_s8", 0, 1'b1, 1'b0);
    tick(); check_b("b_s9", 0, 1'b0, 1'b0);

    // Reset mid-scan, then first post-reset cycles obey scan mode
    rst_n = 1'b0;
    tick();
    check_zero("midrst");
    rst_n = 1'b1;
    tick(); check_b("b_r1", 0, 1'b0, 1'b0);
    tick(); check_b("b_r2", 1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_scan_mux
